// File: rtl/dist_feed.sv
// rtl/dist_feed.sv - query FIFO plus double-buffered search bank feeding dist_sort operands
// Optional issue counter on q_count is enabled by defining DIST_FEED_CNT_EN.
module dist_feed #(
    parameter int DW     = 64,
    parameter int QDEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          sv_wr_en,
    input  logic [2:0]    sv_wr_idx,
    input  logic [DW-1:0] sv_wr_data,
    input  logic          sv_commit,
    input  logic          q_valid,
    input  logic [DW-1:0] q_data,
    output logic          q_ready,
    output logic [DW-1:0] query,
    output logic [DW-1:0] search_0,
    output logic [DW-1:0] search_1,
    output logic [DW-1:0] search_2,
    output logic [DW-1:0] search_3,
    output logic [DW-1:0] search_4,
    output logic [DW-1:0] search_5,
    output logic [DW-1:0] search_6,
    output logic [DW-1:0] search_7,
    output logic          in_valid,
    output logic          commit_err,
    output logic [15:0]   q_count
);
    localparam int AW = $clog2(QDEPTH);

    typedef enum logic {IDLE, RUN} state_t;
    state_t state, state_nxt;

    logic [DW-1:0] shadow   [8];
    logic [DW-1:0] active   [8];
    logic [DW-1:0] srch     [8];
    logic [DW-1:0] fifo_mem [QDEPTH];
    logic [7:0]    mask, mask_wr;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   fifo_count;
    logic          bank_ok, commit_ok, push, pop;

    // A write in the commit cycle counts toward completing the bank.
    always_comb begin
        mask_wr   = mask | (sv_wr_en ? (8'h01 << sv_wr_idx) : 8'h00);
        commit_ok = sv_commit && (mask_wr == 8'hFF);
        q_ready   = fifo_count < (AW+1)'(QDEPTH);
        push      = q_valid && q_ready;
        pop       = bank_ok && (fifo_count != '0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        bank_ok   = 1'b0;
        case (state)
            IDLE: if (commit_ok) state_nxt = RUN;
            RUN:  bank_ok = 1'b1;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mask       <= 8'h00;
            commit_err <= 1'b0;
            for (int k = 0; k < 8; k++) begin
                shadow[k] <= '0;
                active[k] <= '0;
            end
        end else begin
            if (sv_wr_en) shadow[sv_wr_idx] <= sv_wr_data;
            if (commit_ok) begin
                mask <= 8'h00;
                for (int k = 0; k < 8; k++)
                    active[k] <= (sv_wr_en && sv_wr_idx == 3'(k)) ? sv_wr_data : shadow[k];
            end else begin
                mask <= mask_wr;
                if (sv_commit) commit_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= q_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Operands sample the active bank before any same-edge commit lands.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_valid <= 1'b0;
            query    <= '0;
            for (int k = 0; k < 8; k++) srch[k] <= '0;
        end else begin
            in_valid <= pop;
            if (pop) begin
                query <= fifo_mem[rd_ptr];
                for (int k = 0; k < 8; k++) srch[k] <= active[k];
            end
        end
    end

    assign search_0 = srch[0];
    assign search_1 = srch[1];
    assign search_2 = srch[2];
    assign search_3 = srch[3];
    assign search_4 = srch[4];
    assign search_5 = srch[5];
    assign search_6 = srch[6];
    assign search_7 = srch[7];

`ifdef DIST_FEED_CNT_EN
    logic [15:0] cnt;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                            cnt <= 16'h0000;
        else if (in_valid && cnt != 16'hFFFF) cnt <= cnt + 16'h0001;
    end
    assign q_count = cnt;
`else
    assign q_count = 16'h0000;
`endif

endmodule

// File: tb/tb_dist_feed.sv
// tb/tb_dist_feed.sv - testbench for dist_feed: vector table, directed sequences, random vs queue model
module tb_dist_feed;
    localparam int DW = 64;
    localparam int QD = 4;
`ifdef DIST_FEED_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          sv_wr_en = 1'b0, sv_commit = 1'b0, q_valid = 1'b0;
    logic [2:0]    sv_wr_idx = 3'd0;
    logic [DW-1:0] sv_wr_data = '0, q_data = '0;
    logic          q_ready, in_valid, commit_err;
    logic [DW-1:0] query;
    logic [DW-1:0] srch_a [8];
    logic [15:0]   q_count;

    always #5 clk = ~clk;

    dist_feed #(.DW(DW), .QDEPTH(QD)) dut (
        .clk(clk), .rst(rst),
        .sv_wr_en(sv_wr_en), .sv_wr_idx(sv_wr_idx), .sv_wr_data(sv_wr_data), .sv_commit(sv_commit),
        .q_valid(q_valid), .q_data(q_data), .q_ready(q_ready), .query(query),
        .search_0(srch_a[0]), .search_1(srch_a[1]), .search_2(srch_a[2]), .search_3(srch_a[3]),
        .search_4(srch_a[4]), .search_5(srch_a[5]), .search_6(srch_a[6]), .search_7(srch_a[7]),
        .in_valid(in_valid), .commit_err(commit_err), .q_count(q_count)
    );

    int passed = 0;
    int total  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Reference model: the FIFO is a queue, the banks are plain arrays.
    logic [63:0] m_fifo [$];
    logic [63:0] m_shadow [8];
    logic [63:0] m_active [8];
    logic [63:0] m_search [8];
    logic [63:0] m_query;
    logic [7:0]  m_mask;
    bit          m_run, m_valid, m_err;
    int          m_cnt;

    logic [63:0] issued [$];
    int          issued_cyc [$];
    int          cyc_n = 0;

    function automatic void model_reset();
        m_fifo.delete();
        for (int k = 0; k < 8; k++) begin
            m_shadow[k] = '0; m_active[k] = '0; m_search[k] = '0;
        end
        m_query = '0; m_mask = 8'h00; m_run = 0; m_valid = 0; m_err = 0; m_cnt = 0;
    endfunction

    function automatic void model_step(input logic we, input logic [2:0] idx, input logic [63:0] wd,
                                       input logic cm, input logic qv, input logic [63:0] qd);
        bit was_valid = m_valid;
        bit rdy = (m_fifo.size() < QD);
        if (m_run && m_fifo.size() > 0) begin
            m_valid  = 1;
            m_query  = m_fifo.pop_front();
            m_search = m_active;
        end else begin
            m_valid = 0;
        end
        if (qv && rdy) m_fifo.push_back(qd);
        if (we) begin
            m_shadow[idx] = wd;
            m_mask[idx]   = 1'b1;
        end
        if (cm) begin
            if (m_mask == 8'hFF) begin
                m_active = m_shadow; m_mask = 8'h00; m_run = 1;
            end else begin
                m_err = 1;
            end
        end
        if (CNT_EN && was_valid && m_cnt < 65535) m_cnt++;
    endfunction

    task automatic check_model();
        chk("in_valid", in_valid, m_valid);
        chk("q_ready", q_ready, (m_fifo.size() < QD));
        chk("query", query, m_query);
        chk("commit_err", commit_err, m_err);
        chk("q_count", q_count, 64'(m_cnt));
        for (int k = 0; k < 8; k++) chk($sformatf("search_%0d", k), srch_a[k], m_search[k]);
    endtask

    task automatic cyc(input logic we, input logic [2:0] idx, input logic [63:0] wd,
                       input logic cm, input logic qv, input logic [63:0] qd);
        sv_wr_en = we; sv_wr_idx = idx; sv_wr_data = wd; sv_commit = cm; q_valid = qv; q_data = qd;
        model_step(we, idx, wd, cm, qv, qd);
        @(posedge clk);
        #1;
        cyc_n++;
        if (in_valid) begin
            issued.push_back(query);
            issued_cyc.push_back(cyc_n);
        end
        check_model();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 3'd0, 64'h0, 1'b0, 1'b0, 64'h0);
    endtask

    task automatic write_bank(input logic [63:0] base);
        for (int k = 0; k < 8; k++) cyc(1'b1, 3'(k), base + 64'(k), 1'b0, 1'b0, 64'h0);
    endtask

    task automatic do_reset();
        sv_wr_en = 0; sv_commit = 0; q_valid = 0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_in_valid", in_valid, 0);
        chk("rst_query", query, 0);
        chk("rst_search_0", srch_a[0], 0);
        chk("rst_search_7", srch_a[7], 0);
        chk("rst_commit_err", commit_err, 0);
        chk("rst_q_count", q_count, 0);
        chk("rst_q_ready", q_ready, 1);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        we;
        logic [2:0]  idx;
        logic [63:0] wd;
        logic        cm;
        logic        qv;
        logic [63:0] qd;
        logic        e_valid;
        logic [63:0] e_query;
        logic [63:0] e_s0;
        logic        e_ready;
        logic        e_err;
    } vec_t;

    vec_t vt [12];
    bit   acc;

    initial begin
        // Partial commit fails, completing write plus commit succeeds, then one query.
        for (int i = 0; i < 7; i++)
            vt[i] = '{1'b1, 3'(i), 64'h10 + 64'(i), 1'b0, 1'b0, 64'h0, 1'b0, 64'h0, 64'h0, 1'b1, 1'b0};
        vt[7]  = '{1'b0, 3'd0, 64'h0,  1'b1, 1'b0, 64'h0,  1'b0, 64'h0,  64'h0,  1'b1, 1'b1};
        vt[8]  = '{1'b1, 3'd7, 64'h17, 1'b1, 1'b0, 64'h0,  1'b0, 64'h0,  64'h0,  1'b1, 1'b1};
        vt[9]  = '{1'b0, 3'd0, 64'h0,  1'b0, 1'b1, 64'hA5, 1'b0, 64'h0,  64'h0,  1'b1, 1'b1};
        vt[10] = '{1'b0, 3'd0, 64'h0,  1'b0, 1'b0, 64'h0,  1'b1, 64'hA5, 64'h10, 1'b1, 1'b1};
        vt[11] = '{1'b0, 3'd0, 64'h0,  1'b0, 1'b0, 64'h0,  1'b0, 64'hA5, 64'h10, 1'b1, 1'b1};

        #2;
        do_reset();

        for (int i = 0; i < 12; i++) begin
            cyc(vt[i].we, vt[i].idx, vt[i].wd, vt[i].cm, vt[i].qv, vt[i].qd);
            chk($sformatf("vec%0d_in_valid", i), in_valid, vt[i].e_valid);
            chk($sformatf("vec%0d_query", i), query, vt[i].e_query);
            chk($sformatf("vec%0d_search_0", i), srch_a[0], vt[i].e_s0);
            chk($sformatf("vec%0d_search_7", i), srch_a[7], (vt[i].e_s0 == 0) ? 64'h0 : vt[i].e_s0 + 64'h7);
            chk($sformatf("vec%0d_q_ready", i), q_ready, vt[i].e_ready);
            chk($sformatf("vec%0d_commit_err", i), commit_err, vt[i].e_err);
        end
        chk("cnt_after_first_query", q_count, CNT_EN ? 64'd1 : 64'd0);

        // Five queries offered while idle; fifth held until space appears.
        do_reset();
        write_bank(64'h10);
        for (int i = 0; i < 4; i++) cyc(1'b0, 3'd0, 64'h0, 1'b0, 1'b1, 64'h101 + 64'(i));
        chk("full_q_ready", q_ready, 0);
        cyc(1'b0, 3'd0, 64'h0, 1'b0, 1'b1, 64'h105);
        chk("idle_no_issue", in_valid, 0);
        issued.delete(); issued_cyc.delete();
        cyc(1'b0, 3'd0, 64'h0, 1'b1, 1'b1, 64'h105);
        acc = 0;
        for (int t = 0; t < 10 && !acc; t++) begin
            acc = (m_fifo.size() < QD);
            cyc(1'b0, 3'd0, 64'h0, 1'b0, 1'b1, 64'h105);
        end
        chk("fifth_accepted", acc, 1);
        idle(6);
        chk("order_count", issued.size(), 5);
        for (int i = 0; i < 5 && i < issued.size(); i++)
            chk($sformatf("order_%0d", i), issued[i], 64'h101 + 64'(i));
        if (issued_cyc.size() == 5) chk("order_consecutive", issued_cyc[4] - issued_cyc[0], 4);

        // Commit in the same cycle as issue of Q1: Q1 keeps the old bank.
        write_bank(64'h20);
        cyc(1'b0, 3'd0, 64'h0, 1'b0, 1'b1, 64'hB1);
        cyc(1'b0, 3'd0, 64'h0, 1'b1, 1'b1, 64'hB2);
        chk("q1_query", query, 64'hB1);
        chk("q1_search_0", srch_a[0], 64'h10);
        chk("q1_search_7", srch_a[7], 64'h17);
        idle(1);
        chk("q2_query", query, 64'hB2);
        chk("q2_search_0", srch_a[0], 64'h20);
        chk("q2_search_7", srch_a[7], 64'h27);

        // Reset with buffered queries: nothing survives into the next run.
        do_reset();
        for (int i = 0; i < 3; i++) cyc(1'b0, 3'd0, 64'h0, 1'b0, 1'b1, 64'hC0 + 64'(i));
        do_reset();
        issued.delete(); issued_cyc.delete();
        write_bank(64'h30);
        cyc(1'b0, 3'd0, 64'h0, 1'b1, 1'b0, 64'h0);
        idle(4);
        chk("no_issue_after_reset", issued.size(), 0);

        // Ten issued queries.
        do_reset();
        write_bank(64'h40);
        cyc(1'b0, 3'd0, 64'h0, 1'b1, 1'b0, 64'h0);
        for (int i = 0; i < 10; i++) cyc(1'b0, 3'd0, 64'h0, 1'b0, 1'b1, 64'h200 + 64'(i));
        idle(4);
        chk("q_count_ten", q_count, CNT_EN ? 64'd10 : 64'd0);

        // Random traffic against the model.
        do_reset();
        for (int i = 0; i < 400; i++)
            cyc(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), {$urandom, $urandom},
                ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)), {$urandom, $urandom});
        idle(6);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/dist_feed.md
DIST_FEED -- requirements
Module: dist_feed

Interface
REQ-001 SHALL have parameter DW, default 64, width of query and search-vector words.
REQ-002 SHALL have parameter QDEPTH, default 4, query FIFO depth (power of two, >=2).
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port sv_wr_en  input  1  write one search vector into shadow bank.
REQ-006 SHALL have port sv_wr_idx  input  3  shadow bank slot 0..7.
REQ-007 SHALL have port sv_wr_data  input  DW  search vector value.
REQ-008 SHALL have port sv_commit  input  1  pulse: promote shadow bank to active bank.
REQ-009 SHALL have port q_valid  input  1  query offered.
REQ-010 SHALL have port q_data  input  DW  query value.
REQ-011 SHALL have port q_ready  output  1  FIFO can accept a query.
REQ-012 SHALL have ports query, search_0..search_7  output  DW each  registered operands to dist_sort.
REQ-013 SHALL have port in_valid  output  1  operands valid this cycle (drives dist_sort in_valid).
REQ-014 SHALL have port commit_err  output  1  sticky: commit attempted with incomplete shadow bank.
REQ-015 SHALL have port q_count  output  16  number of queries issued.

Function
REQ-016 SHALL keep an 8-bit shadow write mask; sv_wr_en sets bit sv_wr_idx and stores sv_wr_data in shadow slot; rewriting a slot overwrites it.
REQ-017 SHALL, on sv_commit with mask==8'hFF, copy shadow to active bank at that edge, clear mask, set bank_ok.
REQ-018 SHALL, on sv_commit with mask!=8'hFF, leave active bank and mask unchanged and set commit_err until reset.
REQ-019 SHALL, on sv_wr_en and sv_commit in same cycle, apply the write first so a completing write permits the commit.
REQ-020 SHALL drive q_ready = (fifo_count < QDEPTH), independent of same-cycle pop; push occurs on q_valid && q_ready.
REQ-021 SHALL run FSM IDLE (bank_ok=0, no issue) -> RUN on first successful commit; RUN never returns to IDLE except by reset.
REQ-022 SHALL in RUN pop one query per cycle when FIFO non-empty, registering query and all eight active slots; in_valid=1 on the following cycle, else 0.
REQ-023 SHALL give minimum latency: query accepted at edge N appears with in_valid=1 after edge N+1.
REQ-024 SHALL pair a query issued in the same cycle as a commit with the pre-commit bank; the next issued query uses the new bank.
REQ-025 SHALL accept queries in IDLE (buffering up to QDEPTH) and issue them in order once RUN.
REQ-026 SHALL handle simultaneous push and pop without count change; FIFO pointers wrap modulo QDEPTH.
REQ-027 SHALL hold query/search_* outputs at last issued values when in_valid=0.

Reset
REQ-028 SHALL on rst low immediately clear: in_valid=0, q_ready=1 after FIFO cleared, query/search_*=0, active and shadow banks=0, mask=0, bank_ok=0, FSM=IDLE, commit_err=0, q_count=0.
REQ-029 SHALL discard buffered queries when reset asserts mid-operation; no in_valid pulse after deassertion until new queries and a valid commit.

Configuration
REQ-030 SHALL, with DIST_FEED_CNT_EN defined, increment q_count on every in_valid cycle, saturating at 16'hFFFF.
REQ-031 SHALL, without DIST_FEED_CNT_EN, keep q_count port present and tied to 0, with no counter logic.

Verification
REQ-032 Write slots 0..7 with 64'h10..64'h17, commit, push query 64'hA5 -> one in_valid pulse two edges after acceptance, query=A5, search_k=64'h10+k.
REQ-033 Write slots 0..6 only, commit -> commit_err=1, FSM stays IDLE, no in_valid; write slot 7, commit -> RUN, commit_err stays 1.
REQ-034 Push 5 queries in IDLE with QDEPTH=4 -> q_ready=0 after 4th, 5th held; after commit, queries issue in order on 4 consecutive cycles, then 5th.
REQ-035 In RUN, overwrite bank with 64'h20..27, commit same cycle as issue of query Q1 -> Q1 uses old bank, Q2 uses 64'h20..27.
REQ-036 Assert rst low with 3 queries buffered -> all outputs zero asynchronously, no in_valid after release; with DIST_FEED_CNT_EN, q_count=0.
REQ-037 With DIST_FEED_CNT_EN, issue 10 queries -> q_count=10; without macro -> q_count=0.
